// File: rtl/cpu_debug_unit_pkg.sv
// Shared types and constants for the CPU run-control / debug-view unit.
package cpu_debug_unit_pkg;

  // Run-control states; encodings are fixed so debug views can decode them.
  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_RUN  = 2'd1,
    DBG_STEP = 2'd2,
    DBG_HALT = 2'd3
  } dbg_state_t;

  // Upper bound on the number of PC breakpoint comparators.
  localparam int DBG_NBRK_MAX = 8;

endpackage

// File: rtl/cpu_debug_unit_rise_pulse.sv
// One-bit rising-edge detector: a single-cycle pulse when the input goes 0->1.
module cpu_debug_unit_rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic prev;

  // Remember last cycle's input so a held-high level never repeats the pulse.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= sig;
  end

  assign pulse = sig & ~prev;

endmodule

// File: rtl/cpu_debug_unit.sv
// Run-control and debug-view unit for the multi-cycle CPU: continuous run,
// single step, PC breakpoints, instruction counter and the debug view pointer.
module cpu_debug_unit
  import cpu_debug_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8,
  parameter int NBRK   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  succ,
  input  logic                  step,
  input  logic                  inc,
  input  logic                  dec,
  input  logic [NBRK-1:0]       brk_en,
  input  logic [NBRK*WIDTH-1:0] brk_addr,
  input  logic [WIDTH-1:0]      cpu_pc,
  input  logic                  cpu_at_fetch,
  output logic                  cpu_run,
  output logic [ADDR_W-1:0]     m_rf_addr,
  output logic                  halted,
  output logic [NBRK-1:0]       brk_hit,
  output logic [WIDTH-1:0]      instr_cnt
);

  dbg_state_t      state;
  logic            fetched;
  logic            skip;
  logic            succ_rise;
  logic            step_rise;
  logic            inc_rise;
  logic            dec_rise;
  logic [NBRK-1:0] hit_vec;
  logic            match;
  logic            fetch_evt;

  cpu_debug_unit_rise_pulse u_succ_edge (.clk(clk), .rst(rst), .sig(succ), .pulse(succ_rise));
  cpu_debug_unit_rise_pulse u_step_edge (.clk(clk), .rst(rst), .sig(step), .pulse(step_rise));
  cpu_debug_unit_rise_pulse u_inc_edge  (.clk(clk), .rst(rst), .sig(inc),  .pulse(inc_rise));
  cpu_debug_unit_rise_pulse u_dec_edge  (.clk(clk), .rst(rst), .sig(dec),  .pulse(dec_rise));

  // One comparator per breakpoint; combinational so enable/address edits act immediately.
  for (genvar i = 0; i < NBRK; i++) begin : g_brk
    assign hit_vec[i] = brk_en[i] & (brk_addr[i*WIDTH +: WIDTH] == cpu_pc);
  end

  // A breakpoint only fires at a fetch boundary, and not for the instruction we just resumed from.
  assign match     = (|hit_vec) & cpu_at_fetch & ~skip;
  assign fetch_evt = cpu_at_fetch & cpu_run;
  assign halted    = (state == DBG_HALT);

  // CPU advance enable: combinational so a breakpoint or run-stop blocks the fetch in the same cycle.
  always_comb begin
    cpu_run = 1'b0;
    case (state)
      DBG_RUN:  cpu_run = ~match & (succ | ~cpu_at_fetch);
      DBG_STEP: cpu_run = fetched ? ~cpu_at_fetch : ~match;
      default:  cpu_run = 1'b0;
    endcase
  end

  // Run-control state machine together with its step/skip flags and sticky breakpoint hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DBG_IDLE;
      fetched <= 1'b0;
      skip    <= 1'b0;
      brk_hit <= '0;
    end else begin
      if (fetch_evt) skip <= 1'b0;
      case (state)
        DBG_IDLE: begin
          if (succ) begin
            state <= DBG_RUN;
          end else if (step_rise) begin
            state   <= DBG_STEP;
            fetched <= 1'b0;
          end
        end
        DBG_RUN: begin
          if (match) begin
            state   <= DBG_HALT;
            brk_hit <= brk_hit | hit_vec;
          end else if (!succ && cpu_at_fetch) begin
            state <= DBG_IDLE;
          end
        end
        DBG_STEP: begin
          if (!fetched) begin
            if (match) begin
              state   <= DBG_HALT;
              brk_hit <= brk_hit | hit_vec;
            end else if (fetch_evt) begin
              fetched <= 1'b1;
            end
          end else if (cpu_at_fetch) begin
            state <= DBG_IDLE;
          end
        end
        DBG_HALT: begin
          if (succ_rise) begin
            state <= DBG_RUN;
            skip  <= 1'b1;
          end else if (step_rise) begin
            state   <= DBG_STEP;
            fetched <= 1'b0;
            skip    <= 1'b1;
          end
        end
        default: state <= DBG_IDLE;
      endcase
    end
  end

  // Count every instruction the CPU actually starts, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst)            instr_cnt <= '0;
    else if (fetch_evt) instr_cnt <= instr_cnt + WIDTH'(1);
  end

  // Debug view pointer; simultaneous inc and dec edges cancel out.
  always_ff @(posedge clk) begin
    if (rst)                       m_rf_addr <= '0;
    else if (inc_rise && !dec_rise) m_rf_addr <= m_rf_addr + ADDR_W'(1);
    else if (dec_rise && !inc_rise) m_rf_addr <= m_rf_addr - ADDR_W'(1);
  end

endmodule

// File: tb/tb_cpu_debug_unit.sv
// Scoreboard bench for cpu_debug_unit driving a tiny 3-cycle-per-instruction CPU model.
module tb_cpu_debug_unit;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 8;
  localparam int NBRK   = 2;

  localparam int F_RUN  = 0;
  localparam int F_ADDR = 1;
  localparam int F_HALT = 2;
  localparam int F_HIT  = 3;
  localparam int F_CNT  = 4;
  localparam int F_PC   = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  succ;
  logic                  step;
  logic                  inc;
  logic                  dec;
  logic [NBRK-1:0]       brk_en;
  logic [NBRK*WIDTH-1:0] brk_addr;
  logic [WIDTH-1:0]      cpu_pc;
  logic                  cpu_at_fetch;
  logic                  cpu_run;
  logic [ADDR_W-1:0]     m_rf_addr;
  logic                  halted;
  logic [NBRK-1:0]       brk_hit;
  logic [WIDTH-1:0]      instr_cnt;

  logic [1:0]            phase;
  logic [WIDTH-1:0]      model_pc;

  string                 name_q[$];
  int                    field_q[$];
  logic [31:0]           exp_q[$];
  int                    checks = 0;
  int                    errors = 0;

  cpu_debug_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NBRK(NBRK)) dut (
    .clk(clk), .rst(rst), .succ(succ), .step(step), .inc(inc), .dec(dec),
    .brk_en(brk_en), .brk_addr(brk_addr), .cpu_pc(cpu_pc), .cpu_at_fetch(cpu_at_fetch),
    .cpu_run(cpu_run), .m_rf_addr(m_rf_addr), .halted(halted), .brk_hit(brk_hit),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Reference CPU: fetch at phase 0 (PC += 4), then two execute cycles, only on enabled edges.
  always @(posedge clk) begin
    if (rst) begin
      model_pc <= '0;
      phase    <= 2'd0;
    end else if (cpu_run) begin
      if (phase == 2'd0) begin
        model_pc <= model_pc + 32'd4;
        phase    <= 2'd1;
      end else if (phase == 2'd1) begin
        phase <= 2'd2;
      end else begin
        phase <= 2'd0;
      end
    end
  end

  assign cpu_pc       = model_pc;
  assign cpu_at_fetch = (phase == 2'd0);

  // Monitor: on each falling edge, pop every pending expectation and compare it with the outputs.
  always @(negedge clk) begin : monitor
    string       nm;
    int          f;
    logic [31:0] e;
    logic [31:0] act;
    while (name_q.size() > 0) begin
      nm = name_q.pop_front();
      f  = field_q.pop_front();
      e  = exp_q.pop_front();
      case (f)
        F_RUN:   act = {31'd0, cpu_run};
        F_ADDR:  act = {24'd0, m_rf_addr};
        F_HALT:  act = {31'd0, halted};
        F_HIT:   act = {30'd0, brk_hit};
        F_CNT:   act = instr_cnt;
        F_PC:    act = model_pc;
        default: act = 32'hDEAD_BEEF;
      endcase
      checks++;
      if (act !== e) begin
        errors++;
        $display("[TB] FAIL %s actual=0x%0h required=0x%0h", nm, act, e);
      end
    end
  end

  // Safety net so the run always ends even if something stalls forever.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic i, input logic d);
    succ = s;
    step = st;
    inc  = i;
    dec  = d;
  endtask

  task automatic checkOutput(input string nm, input int f, input logic [31:0] e);
    name_q.push_back(nm);
    field_q.push_back(f);
    exp_q.push_back(e);
  endtask

  task automatic timeoutFail(input string nm);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=event", nm);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
  endtask

  task automatic waitHalt(input string nm, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick(1);
      n++;
    end
    if (!halted) timeoutFail(nm);
  endtask

  task automatic waitPc(input string nm, input logic [31:0] target, input int budget);
    int n = 0;
    while (model_pc != target && n < budget) begin
      tick(1);
      n++;
    end
    if (model_pc != target) timeoutFail(nm);
  endtask

  task automatic waitPhase1(input string nm, input int budget);
    int n = 0;
    while (phase != 2'd1 && n < budget) begin
      tick(1);
      n++;
    end
    if (phase != 2'd1) timeoutFail(nm);
  endtask

  initial begin
    rst      = 1'b1;
    brk_en   = '0;
    brk_addr = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_run",  F_RUN,  32'd0);
    checkOutput("rst_addr", F_ADDR, 32'd0);
    checkOutput("rst_cnt",  F_CNT,  32'd0);
    checkOutput("rst_halt", F_HALT, 32'd0);
    checkOutput("rst_hit",  F_HIT,  32'd0);
    tick(1);

    $display("[TB] single step from IDLE");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(12);
    checkOutput("step_cnt",  F_CNT,  32'd1);
    checkOutput("step_pc",   F_PC,   32'h4);
    checkOutput("step_run",  F_RUN,  32'd0);
    checkOutput("step_halt", F_HALT, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(50);
    checkOutput("step_held_cnt", F_CNT, 32'd2);
    checkOutput("step_held_pc",  F_PC,  32'h8);
    checkOutput("step_held_run", F_RUN, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);

    $display("[TB] run into breakpoint 0 and resume");
    doReset();
    brk_en   = 2'b01;
    brk_addr = {32'h0, 32'h10};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitHalt("brk0_wait", 100);
    checkOutput("brk0_halt", F_HALT, 32'd1);
    checkOutput("brk0_pc",   F_PC,   32'h10);
    checkOutput("brk0_cnt",  F_CNT,  32'd4);
    checkOutput("brk0_hit",  F_HIT,  32'b01);
    checkOutput("brk0_run",  F_RUN,  32'd0);
    tick(5);
    checkOutput("brk0_stay_halt", F_HALT, 32'd1);
    checkOutput("brk0_stay_cnt",  F_CNT,  32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitPc("resume_wait", 32'h20, 100);
    checkOutput("resume_halt", F_HALT, 32'd0);
    checkOutput("resume_cnt",  F_CNT,  32'd8);
    checkOutput("resume_hit",  F_HIT,  32'b01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(10);

    $display("[TB] breakpoint 1 then single step out of HALT");
    doReset();
    checkOutput("rst2_hit", F_HIT, 32'd0);
    brk_en   = 2'b11;
    brk_addr = {32'h10, 32'h40};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitHalt("brk1_wait", 100);
    checkOutput("brk1_hit", F_HIT, 32'b10);
    checkOutput("brk1_cnt", F_CNT, 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(12);
    checkOutput("hstep_pc",   F_PC,   32'h14);
    checkOutput("hstep_cnt",  F_CNT,  32'd5);
    checkOutput("hstep_halt", F_HALT, 32'd0);
    checkOutput("hstep_run",  F_RUN,  32'd0);
    checkOutput("hstep_hit",  F_HIT,  32'b10);
    tick(1);

    $display("[TB] succ dropped mid-instruction");
    doReset();
    brk_en = 2'b00;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitPhase1("mid_wait", 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_run", F_RUN, 32'd1);
    tick(2);
    checkOutput("bound_run", F_RUN, 32'd0);
    checkOutput("bound_pc",  F_PC,  32'h4);
    checkOutput("bound_cnt", F_CNT, 32'd1);
    tick(5);
    checkOutput("idle_cnt", F_CNT, 32'd1);
    checkOutput("idle_pc",  F_PC,  32'h4);

    $display("[TB] view pointer and reset during RUN");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ptr_dec_wrap", F_ADDR, 32'hFF);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ptr_inc_wrap", F_ADDR, 32'h00);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ptr_inc", F_ADDR, 32'h01);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ptr_both", F_ADDR, 32'h01);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(10);
    checkOutput("ptr_held", F_ADDR, 32'h02);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(6);
    checkOutput("run_cnt", F_CNT, 32'd2);
    rst = 1'b1;
    tick(1);
    checkOutput("rrun_run",  F_RUN,  32'd0);
    checkOutput("rrun_addr", F_ADDR, 32'd0);
    checkOutput("rrun_cnt",  F_CNT,  32'd0);
    checkOutput("rrun_halt", F_HALT, 32'd0);
    checkOutput("rrun_hit",  F_HIT,  32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
